// File: rtl/iob_axi_slave_pkg.sv
// Shared constants and types for the iob AXI4 responder.
// Optional feature macro: IOB_AXI_SLAVE_WRAP_EN (enables WRAP burst decoding).
package iob_axi_slave_pkg;

    localparam int AXI_LEN_W = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

`ifdef IOB_AXI_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_RESP = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } rr_t;

    // A burst is answered with SLVERR when its type cannot be honoured.
    // WRAP with a length other than 2/4/8/16 beats has no power-of-two window.
    function automatic logic burst_is_err(input logic [1:0] burst,
                                          input logic [AXI_LEN_W-1:0] len);
        logic err;
        err = 1'b0;
        case (burst)
            AXI_BURST_FIXED, AXI_BURST_INCR: err = 1'b0;
            AXI_BURST_WRAP:
                err = WRAP_EN ? !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                              : 1'b1;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/iob_axi_burst_addr.sv
// Beat address generator shared by the write and read paths.
// WRAP windows are honoured only when IOB_AXI_SLAVE_WRAP_EN is defined;
// otherwise WRAP and the reserved encoding step like INCR.
module iob_axi_burst_addr
    import iob_axi_slave_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [ADDR_W-1:0]    i_load_addr,
    input  logic                 i_advance,
    input  logic [2:0]           i_size,
    input  logic [AXI_LEN_W-1:0] i_len,
    input  logic [1:0]           i_burst,
    output logic [ADDR_W-1:0]    o_addr
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_incr_addr;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_wrap_addr;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_incr      = ONE << i_size;
    assign w_incr_addr = r_addr + w_incr;
    // Window is (len+1)<<size bytes; the low bits advance, the high bits stay put.
    assign w_wrap_mask = (({{(ADDR_W-AXI_LEN_W){1'b0}}, i_len} + ONE) << i_size) - ONE;
    assign w_wrap_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);

    // Select the following beat address by burst type.
    always_comb begin
        w_next_addr = w_incr_addr;
        case (i_burst)
            AXI_BURST_FIXED: w_next_addr = r_addr;
            AXI_BURST_WRAP:  w_next_addr = WRAP_EN ? w_wrap_addr : w_incr_addr;
            default:         w_next_addr = w_incr_addr;
        endcase
    end

    // Current beat address: loaded on grant, stepped after each completed iob access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
        end else if (i_advance) begin
            r_addr <= w_next_addr;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/iob_axi_slave.sv
// AXI4 responder that serialises every burst beat into one native iob access.
// One transaction at a time, reads and writes arbitrated round-robin.
// Optional feature macro: IOB_AXI_SLAVE_WRAP_EN (legal WRAP bursts).
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  ST_IDLE    | awready/arready offered to the granted channel
//  ST_WR_DATA | accept W beats into a one-entry buffer, issue iob writes
//  ST_WR_RESP | hold B response until bready
//  ST_RD_DATA | issue iob reads into the R holding register until rlast drains
module iob_axi_slave
    import iob_axi_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic                  iob_valid,
    output logic [ADDR_W-1:0]     iob_addr,
    output logic [DATA_W-1:0]     iob_wdata,
    output logic [DATA_W/8-1:0]   iob_wstrb,
    input  logic [DATA_W-1:0]     iob_rdata,
    input  logic                  iob_ready
);

    state_t                 r_state;
    rr_t                    r_rr_last;
    logic [ID_W-1:0]        r_id;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [2:0]             r_size;
    logic [1:0]             r_burst;
    logic [AXI_LEN_W-1:0]   r_beat_cnt;
    logic                   r_err;

    logic                   r_wbuf_full;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_wstrb;

    logic                   r_bvalid;

    logic                   r_rvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_rlast;
    logic                   r_rd_done;
    logic                   r_iob_pend;

    logic                   w_idle;
    logic                   w_grant_w;
    logic                   w_grant_r;
    logic                   w_last_beat;
    logic                   w_w_accept;
    logic                   w_iob_valid_wr;
    logic                   w_iob_valid_rd;
    logic                   w_iob_done;
    logic [ADDR_W-1:0]      w_addr;

    assign w_idle      = (r_state == ST_IDLE);
    // On contention the channel not served last wins.
    assign w_grant_w   = w_idle && s_axi_awvalid && (!s_axi_arvalid || (r_rr_last == RR_READ));
    assign w_grant_r   = w_idle && s_axi_arvalid && (!s_axi_awvalid || (r_rr_last == RR_WRITE));
    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_w_accept  = s_axi_wvalid && s_axi_wready;

    assign w_iob_valid_wr = (r_state == ST_WR_DATA) && r_wbuf_full;
    // Once raised, a read request is held until iob_ready even if rready drops.
    assign w_iob_valid_rd = (r_state == ST_RD_DATA) && !r_rd_done
                            && (r_iob_pend || !r_rvalid || s_axi_rready);
    assign w_iob_done     = (w_iob_valid_wr || w_iob_valid_rd) && iob_ready;

    iob_axi_burst_addr #(
        .ADDR_W (ADDR_W)
    ) u_burst_addr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_grant_w || w_grant_r),
        .i_load_addr (w_grant_w ? s_axi_awaddr : s_axi_araddr),
        .i_advance   (w_iob_done),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_addr      (w_addr)
    );

    // Transaction sequencing, W buffering and R/B response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= RR_WRITE;
            r_id        <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
            r_wbuf_full <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rlast     <= 1'b0;
            r_rd_done   <= 1'b0;
            r_iob_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_w) begin
                        r_id       <= s_axi_awid;
                        r_len      <= s_axi_awlen;
                        r_size     <= s_axi_awsize;
                        r_burst    <= s_axi_awburst;
                        r_err      <= burst_is_err(s_axi_awburst, s_axi_awlen);
                        r_beat_cnt <= '0;
                        r_rr_last  <= RR_WRITE;
                        r_state    <= ST_WR_DATA;
                    end else if (w_grant_r) begin
                        r_id       <= s_axi_arid;
                        r_len      <= s_axi_arlen;
                        r_size     <= s_axi_arsize;
                        r_burst    <= s_axi_arburst;
                        r_err      <= burst_is_err(s_axi_arburst, s_axi_arlen);
                        r_beat_cnt <= '0;
                        r_rd_done  <= 1'b0;
                        r_iob_pend <= 1'b0;
                        r_rr_last  <= RR_READ;
                        r_state    <= ST_RD_DATA;
                    end
                end

                ST_WR_DATA: begin
                    // The buffer holds one beat, so the accepted beat index equals r_beat_cnt.
                    if (w_w_accept) begin
                        r_wbuf_full <= 1'b1;
                        r_wdata     <= s_axi_wdata;
                        r_wstrb     <= s_axi_wstrb;
                        if (s_axi_wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (w_iob_done) begin
                        r_wbuf_full <= 1'b0;
                        if (w_last_beat) begin
                            r_bvalid <= 1'b1;
                            r_state  <= ST_WR_RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end

                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

                ST_RD_DATA: begin
                    r_iob_pend <= w_iob_valid_rd && !iob_ready;
                    if (w_iob_done) begin
                        r_rdata  <= iob_rdata;
                        r_rvalid <= 1'b1;
                        r_rlast  <= w_last_beat;
                        if (w_last_beat) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end else if (r_rvalid && s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_awready = w_grant_w;
    assign s_axi_arready = w_grant_r;
    assign s_axi_wready  = (r_state == ST_WR_DATA) && !r_wbuf_full;

    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_id;
    assign s_axi_bresp   = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_id;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    assign iob_valid     = w_iob_valid_wr || w_iob_valid_rd;
    assign iob_addr      = w_addr;
    assign iob_wdata     = r_wdata;
    assign iob_wstrb     = (r_state == ST_WR_DATA) ? r_wstrb : '0;

endmodule

// File: tb/tb_iob_axi_slave.sv
// Directed bench for iob_axi_slave. Expectations follow IOB_AXI_SLAVE_WRAP_EN
// when the macro is defined for the build.
module tb_iob_axi_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;

    logic              clk;
    logic              rst;
    logic [ID_W-1:0]   s_axi_awid;
    logic [31:0]       s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic [2:0]        s_axi_awsize;
    logic [1:0]        s_axi_awburst;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [ID_W-1:0]   s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ID_W-1:0]   s_axi_arid;
    logic [31:0]       s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              iob_valid;
    logic [31:0]       iob_addr;
    logic [31:0]       iob_wdata;
    logic [3:0]        iob_wstrb;
    logic [31:0]       iob_rdata;
    logic              iob_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_wstrb[$];

    logic [31:0]     rd_data[16];
    logic            rd_last[16];
    logic [1:0]      rd_resp[16];
    logic [ID_W-1:0] rd_id[16];
    int              n_rd;
    int              stall_bad;
    logic [1:0]      b_resp;
    logic [ID_W-1:0] b_id;

    iob_axi_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .iob_valid     (iob_valid),
        .iob_addr      (iob_addr),
        .iob_wdata     (iob_wdata),
        .iob_wstrb     (iob_wstrb),
        .iob_rdata     (iob_rdata),
        .iob_ready     (iob_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is a fixed tag plus the low address bits.
    assign iob_rdata = 32'hC0DE_0000 | {16'h0000, iob_addr[15:0]};

    // Log every completed iob access.
    always @(negedge clk) begin
        if (!rst && iob_valid && iob_ready) begin
            q_addr.push_back(iob_addr);
            q_wdata.push_back(iob_wdata);
            q_wstrb.push_back(iob_wstrb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        if (i < q_addr.size()) return q_addr[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qw(input int i);
        if (i < q_wdata.size()) return q_wdata[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qs(input int i);
        if (i < q_wstrb.size()) return 32'(q_wstrb[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic q_clear();
        q_addr.delete();
        q_wdata.delete();
        q_wstrb.delete();
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [31:0] data0,
                            input logic [3:0] strb, input int wlast_idx);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 200);
        if (!s_axi_awready) chk("aw_timeout", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = data0 + 32'(b);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (b == wlast_idx);
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < 200);
            if (!s_axi_wready) chk("w_timeout", 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 200);
        if (!s_axi_bvalid) chk("b_timeout", 32'(s_axi_bvalid), 32'd1);
        b_resp = s_axi_bresp;
        b_id   = s_axi_bid;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_beat);
        int n;
        logic [31:0] held;
        n_rd = 0;
        stall_bad = 0;
        s_axi_rready = 1'b1;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
        if (!s_axi_arready) chk("ar_timeout", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == stall_beat) begin
                s_axi_rready = 1'b0;
                n = 0;
                do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 200);
                held = s_axi_rdata;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    if (!s_axi_rvalid || s_axi_rdata !== held || iob_valid) stall_bad++;
                end
                @(posedge clk); #1;
                s_axi_rready = 1'b1;
            end
            n = 0;
            do begin @(negedge clk); n++; end while (!(s_axi_rvalid && s_axi_rready) && n < 200);
            if (!s_axi_rvalid) chk("r_timeout", 32'(s_axi_rvalid), 32'd1);
            rd_data[b] = s_axi_rdata;
            rd_last[b] = s_axi_rlast;
            rd_resp[b] = s_axi_rresp;
            rd_id[b]   = s_axi_rid;
            n_rd++;
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] lp;
        logic [1:0] rr_or;

        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        iob_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 32'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                               s_axi_rvalid, s_axi_rlast, iob_valid}), 32'd0);
        chk("reset_iob_addr", iob_addr, 32'd0);
        chk("reset_iob_wstrb", 32'(iob_wstrb), 32'd0);
        chk("reset_rdata", s_axi_rdata, 32'd0);
        chk("reset_resp", 32'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}), 32'd0);
        @(posedge clk); #1;

        // Single-beat write.
        q_clear();
        do_write(1'b1, 32'h100, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 0);
        chk("t1_n_acc", 32'(q_addr.size()), 32'd1);
        chk("t1_addr", qa(0), 32'h100);
        chk("t1_wdata", qw(0), 32'hDEAD_BEEF);
        chk("t1_wstrb", qs(0), 32'hF);
        chk("t1_bresp", 32'(b_resp), 32'd0);
        chk("t1_bid", 32'(b_id), 32'd1);

        // INCR read, 4 beats, no back-pressure.
        q_clear();
        do_read(1'b1, 32'h200, 8'd3, 3'd2, 2'b01, -1);
        chk("t2_n_acc", 32'(q_addr.size()), 32'd4);
        lp = '0;
        rr_or = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_addr%0d", i), qa(i), 32'h200 + 32'(4 * i));
            chk($sformatf("t2_rdata%0d", i), rd_data[i], 32'hC0DE_0200 + 32'(4 * i));
            lp[i] = rd_last[i];
            rr_or = rr_or | rd_resp[i];
        end
        chk("t2_wstrb_rd", qs(0) | qs(1) | qs(2) | qs(3), 32'd0);
        chk("t2_rlast", 32'(lp), 32'h8);
        chk("t2_rresp", 32'(rr_or), 32'd0);
        chk("t2_rid", 32'(rd_id[3]), 32'd1);

        // Same read with beat 1 held under rready=0.
        q_clear();
        do_read(1'b0, 32'h200, 8'd3, 3'd2, 2'b01, 1);
        chk("t3_stall_bad", 32'(stall_bad), 32'd0);
        chk("t3_n_acc", 32'(q_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_rdata%0d", i), rd_data[i], 32'hC0DE_0200 + 32'(4 * i));
        chk("t3_rid", 32'(rd_id[0]), 32'd0);

        // Write len=3 with wlast on the wrong beat.
        q_clear();
        do_write(1'b0, 32'h300, 8'd3, 3'd2, 2'b01, 32'h5000, 4'hF, 2);
        chk("t5_n_acc", 32'(q_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_addr%0d", i), qa(i), 32'h300 + 32'(4 * i));
            chk($sformatf("t5_wdata%0d", i), qw(i), 32'h5000 + 32'(i));
        end
        chk("t5_bresp", 32'(b_resp), 32'd2);

        // FIXED write with zero strobes: both beats still issued at the same address.
        q_clear();
        do_write(1'b0, 32'h500, 8'd1, 3'd2, 2'b00, 32'hA0, 4'h0, 1);
        chk("fx_n_acc", 32'(q_addr.size()), 32'd2);
        chk("fx_addr0", qa(0), 32'h500);
        chk("fx_addr1", qa(1), 32'h500);
        chk("fx_wdata1", qw(1), 32'hA1);
        chk("fx_bresp", 32'(b_resp), 32'd0);

        // Reserved burst encoding: INCR stepping with SLVERR.
        q_clear();
        do_read(1'b0, 32'h600, 8'd1, 3'd2, 2'b11, -1);
        chk("rsv_addr1", qa(1), 32'h604);
        chk("rsv_rresp0", 32'(rd_resp[0]), 32'd2);
        chk("rsv_rresp1", 32'(rd_resp[1]), 32'd2);

        // WRAP read.
        q_clear();
        do_read(1'b0, 32'h38, 8'd3, 3'd2, 2'b10, -1);
        chk("wr_n_acc", 32'(q_addr.size()), 32'd4);
`ifdef IOB_AXI_SLAVE_WRAP_EN
        chk("wr_addr0", qa(0), 32'h38);
        chk("wr_addr1", qa(1), 32'h3C);
        chk("wr_addr2", qa(2), 32'h30);
        chk("wr_addr3", qa(3), 32'h34);
        chk("wr_rresp", 32'(rd_resp[3]), 32'd0);
`else
        chk("wr_addr0", qa(0), 32'h38);
        chk("wr_addr1", qa(1), 32'h3C);
        chk("wr_addr2", qa(2), 32'h40);
        chk("wr_addr3", qa(3), 32'h44);
        chk("wr_rresp", 32'(rd_resp[3]), 32'd2);
`endif

        // Reset in the middle of a read burst with an iob access outstanding.
        q_clear();
        iob_ready = 1'b0;
        s_axi_rready = 1'b0;
        s_axi_arid = 1'b1; s_axi_araddr = 32'h400; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
            if (!s_axi_arready) chk("rst_ar_timeout", 32'(s_axi_arready), 32'd1);
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pre_iob_valid", 32'(iob_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                                 s_axi_rvalid, s_axi_rlast, iob_valid}), 32'd0);
        chk("rst_mid_addr", iob_addr, 32'd0);
        chk("rst_mid_rdata", s_axi_rdata, 32'd0);
        chk("rst_mid_id", 32'({s_axi_rid, s_axi_bid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        iob_ready = 1'b1;
        s_axi_rready = 1'b1;
        q_clear();

        // Two simultaneous aw/ar pairs after reset: read first, then write.
        s_axi_awid = 1'b0; s_axi_awaddr = 32'h700; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
        s_axi_arid = 1'b1; s_axi_araddr = 32'h800; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("rr1_arready", 32'(s_axi_arready), 32'd1);
        chk("rr1_awready", 32'(s_axi_awready), 32'd0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 200);
            chk("rr1_rdata", s_axi_rdata, 32'hC0DE_0800);
            chk("rr1_rlast", 32'(s_axi_rlast), 32'd1);
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("rr2_awready", 32'(s_axi_awready), 32'd1);
        chk("rr2_arready", 32'(s_axi_arready), 32'd0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1122_3344; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < 200);
            if (!s_axi_wready) chk("rr2_w_timeout", 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
            s_axi_wvalid = 1'b0;
            s_axi_wlast  = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 200);
            chk("rr2_bvalid", 32'(s_axi_bvalid), 32'd1);
            chk("rr2_bresp", 32'(s_axi_bresp), 32'd0);
        end
        @(posedge clk); #1;
        chk("rr_n_acc", 32'(q_addr.size()), 32'd2);
        chk("rr_wr_addr", qa(1), 32'h700);
        chk("rr_wr_wdata", qw(1), 32'h1122_3344);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
